// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the handler entry address used by the F stage.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int EXC_LO  = 2;
  localparam int EXC_HI  = 6;
  localparam int BD_BIT  = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // SR bits that physically exist; every other SR bit reads as zero.
  localparam logic [31:0] SR_IMPL = 32'h0000_FC03;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId, interrupt vs. exception
// arbitration, and the pipeline-wide flush request Req.
module cp0_exc_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] SR_WMASK = 32'h0000_FC03,
  parameter logic [31:0] PRID_VAL = 32'h2023_0707
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] pc,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCout,
  output logic        Req
);

  logic [31:0] sr_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_wdata;
  logic [31:0] cause_val;

  wire exl = sr_q[EXL_BIT];
  wire ie  = sr_q[IE_BIT];
  wire [5:0] im = sr_q[IM_HI:IM_LO];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int_req = 1'b0;
    exc_req = 1'b0;
    if (!exl) begin
      int_req = (|(HWInt & im)) & ie;
      exc_req = (ExcCodeIn != 5'd0);
    end
    Req = int_req | exc_req;
  end

  // mtc0 data merged into SR; an eret in the same cycle still wins on EXL.
  always_comb begin
    sr_wdata = ((sr_q & ~SR_WMASK) | (Din & SR_WMASK)) & SR_IMPL;
    if (EXLClr) sr_wdata[EXL_BIT] = 1'b0;
  end

  always_comb begin
    cause_val                 = '0;
    cause_val[BD_BIT]         = bd_q;
    cause_val[IP_HI:IP_LO]    = ip_q;
    cause_val[EXC_HI:EXC_LO]  = exc_q;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip_q <= HWInt;
      if (Req) begin
        exc_q          <= int_req ? EXC_INT : ExcCodeIn;
        bd_q           <= BDIn;
        epc_q          <= epc_of(pc, BDIn);
        sr_q[EXL_BIT]  <= 1'b1;
      end else begin
        if (WE && A2 == REG_SR) begin
          sr_q <= sr_wdata;
        end else if (EXLClr) begin
          sr_q[EXL_BIT] <= 1'b0;
        end
        if (WE && A2 == REG_EPC) epc_q <= Din;
      end
    end
  end

  always_comb begin
    unique case (A1)
      REG_SR:    Dout = sr_q & SR_IMPL;
      REG_CAUSE: Dout = cause_val;
      REG_EPC:   Dout = epc_q;
      REG_PRID:  Dout = PRID_VAL;
      default:   Dout = '0;
    endcase
  end

  assign EPCout = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: stimulus pushes expected Req/Dout/EPCout
// values tagged with a cycle number; a monitor pops and compares at negedge.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1, A2;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] pc;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] Dout, EPCout;
  logic        Req;

  cp0_exc_unit dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .Din(Din), .WE(WE), .pc(pc),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .Dout(Dout), .EPCout(EPCout), .Req(Req)
  );

  always #5 clk = ~clk;

  typedef enum int { K_REQ, K_DOUT, K_EPC } kind_e;
  typedef struct {
    int          cyc;
    string       name;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything expected for the current cycle is compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.kind)
          K_REQ:   act = {31'd0, Req};
          K_DOUT:  act = Dout;
          default: act = EPCout;
        endcase
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", e.name, e.cyc, cyc);
        end else if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
        end
      end
    end
  end

  task automatic push(input string name, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_req(input string n, input logic v);
    push(n, K_REQ, {31'd0, v});
  endtask
  task automatic exp_dout(input string n, input logic [31:0] v);
    push(n, K_DOUT, v);
  endtask
  task automatic exp_epc(input string n, input logic [31:0] v);
    push(n, K_EPC, v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    A1 = 5'd0; A2 = 5'd0; Din = '0; WE = 1'b0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    WE = 1'b1; A2 = r; Din = d;
  endtask

  initial begin
    rst = 1'b1; HWInt = '0; pc = 32'h0000_3000;
    idle();
    step(); step();
    rst = 1'b0;

    // Reset state
    idle(); A1 = 5'd12;
    exp_dout("rst_sr", 32'h0); exp_req("rst_req", 1'b0); exp_epc("rst_epc", 32'h0);
    step();
    idle(); A1 = 5'd15;
    exp_dout("prid", 32'h2023_0707);
    step();

    // mtc0 SR, no bypass on same-cycle read
    idle(); mtc0(5'd12, 32'h0000_FC01); A1 = 5'd12;
    exp_dout("sr_nobypass", 32'h0); exp_req("req_idle", 1'b0);
    step();
    idle(); A1 = 5'd12;
    exp_dout("sr_fc01", 32'h0000_FC01); exp_req("req_hw0", 1'b0);
    step();

    // Interrupt entry
    idle(); mtc0(5'd12, 32'h0000_0401);
    step();
    idle(); HWInt = 6'b000001; pc = 32'h0000_3010; A1 = 5'd12;
    exp_dout("sr_401", 32'h0000_0401); exp_req("int_req", 1'b1);
    step();
    idle(); A1 = 5'd13;
    exp_dout("cause_int", 32'h0000_0400); exp_req("exl_blocks_int", 1'b0);
    exp_epc("epc_int", 32'h0000_3010);
    step();
    idle(); A1 = 5'd12;
    exp_dout("sr_exl", 32'h0000_0403); exp_req("exl_blocks_int2", 1'b0);
    step();

    // eret with mtc0 trying to set EXL: clear wins
    idle(); HWInt = '0; EXLClr = 1'b1; mtc0(5'd12, 32'h0000_0002); A1 = 5'd12;
    exp_dout("sr_pre_eret", 32'h0000_0403); exp_req("req_eret_cyc", 1'b0);
    step();
    idle(); A1 = 5'd12;
    exp_dout("sr_after_eret", 32'h0); exp_req("req_quiet", 1'b0);
    step();

    // Overflow in delay slot, IE=0
    idle(); ExcCodeIn = 5'd12; BDIn = 1'b1; pc = 32'h0000_3024;
    exp_req("ov_req", 1'b1);
    step();
    idle(); ExcCodeIn = 5'd12; A1 = 5'd13;
    exp_dout("cause_ov_bd", 32'h8000_0030); exp_epc("epc_bd", 32'h0000_3020);
    exp_req("no_nesting", 1'b0);
    step();
    idle(); A1 = 5'd12;
    exp_dout("sr_exl_only", 32'h0000_0002);
    step();

    // Interrupt beats simultaneous RI
    idle(); EXLClr = 1'b1; mtc0(5'd12, 32'h0000_1001);
    exp_req("req_eret2", 1'b0);
    step();
    idle(); HWInt = 6'b000100; ExcCodeIn = 5'd10; pc = 32'h0000_3040; A1 = 5'd12;
    exp_dout("sr_1001", 32'h0000_1001); exp_req("int_vs_ri", 1'b1);
    step();
    idle(); A1 = 5'd13;
    exp_dout("cause_int_wins", 32'h0000_1000); exp_epc("epc_int_wins", 32'h0000_3040);
    exp_req("req_held", 1'b0);
    step();

    // Pending interrupt taken right after eret
    idle(); EXLClr = 1'b1; pc = 32'h0000_3050; A1 = 5'd12;
    exp_dout("sr_1003", 32'h0000_1003); exp_req("req_during_eret", 1'b0);
    step();
    idle(); pc = 32'h0000_3058;
    exp_req("int_after_eret", 1'b1); exp_epc("epc_before_retake", 32'h0000_3040);
    step();
    idle(); A1 = 5'd14;
    exp_dout("epc_read", 32'h0000_3058); exp_epc("epc_retake", 32'h0000_3058);
    exp_req("req_after_retake", 1'b0);
    step();

    // SR write mask, Cause write ignored, EPC write unaligned
    idle(); HWInt = '0; mtc0(5'd12, 32'hFFFF_FFFF); A1 = 5'd12;
    exp_dout("sr_prewrite", 32'h0000_1003);
    step();
    idle(); mtc0(5'd13, 32'hFFFF_FFFF); A1 = 5'd12;
    exp_dout("sr_masked", 32'h0000_FC03);
    step();
    idle(); A1 = 5'd13;
    exp_dout("cause_unwritten", 32'h0);
    step();
    idle(); mtc0(5'd14, 32'h1234_5677);
    exp_epc("epc_prewrite", 32'h0000_3058);
    step();
    idle(); A1 = 5'd14;
    exp_dout("epc_mtc0", 32'h1234_5677); exp_epc("epcout_mtc0", 32'h1234_5677);
    step();

    // Reset mid-handler
    idle(); rst = 1'b1; HWInt = 6'b000001;
    exp_req("req_in_reset", 1'b0);
    step();
    rst = 1'b0;
    idle(); A1 = 5'd12;
    exp_dout("sr_after_rst", 32'h0); exp_epc("epc_after_rst", 32'h0);
    exp_req("req_after_rst", 1'b0);
    step();
    idle(); A1 = 5'd13;
    exp_dout("ip_tracks", 32'h0000_0400);
    step();

    // Req discards coincident mtc0 and eret
    idle(); mtc0(5'd12, 32'h0000_0401);
    step();
    idle(); mtc0(5'd14, 32'hDEAD_BEEF); EXLClr = 1'b1; pc = 32'h0000_3100;
    exp_req("req_with_mtc0", 1'b1);
    step();
    idle(); A1 = 5'd12; HWInt = '0;
    exp_dout("eret_discarded", 32'h0000_0403); exp_epc("mtc0_discarded", 32'h0000_3100);
    step();
    idle(); A1 = 5'd5;
    exp_dout("unmapped_reg", 32'h0);
    step();

    step(); step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
